// File: rtl/rot_addsub_param.sv
// Rotary-encoder driven adder/subtractor: nibbles of A and B are entered one per detent, then the op.
// Optional signed-overflow flag is built only when ROT_ADDSUB_OVERFLOW_EN is defined.
module rot_addsub_param #(
  parameter int WIDTH = 8,
  parameter int NIB   = (WIDTH + 3) / 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ROT_A,
  input  logic             ROT_B,
  input  logic [3:0]       Y,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             valid,
  output logic [1:0]       state
);

  localparam int            KW     = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_OP     = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // Bit 0 carries phase A, bit 1 carries phase B.
  logic [1:0]       rot_meta_q;
  logic [1:0]       rot_sync_q;
  logic             rq_q, rq_d;
  logic             rq_prev_q;
  logic             rot_event;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             op_q, op_d;
  logic             load_a, load_b, clr_ops, res_upd;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   res_full;

  // rq only changes when both phases agree, so chatter on a single phase cannot retrigger it.
  always_comb begin
    rq_d = rq_q;
    if (rot_sync_q == 2'b11) begin
      rq_d = 1'b1;
    end else if (rot_sync_q == 2'b00) begin
      rq_d = 1'b0;
    end
  end

  assign rot_event = rq_q & ~rq_prev_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    valid_d = valid_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    clr_ops = 1'b0;
    res_upd = 1'b0;
    if (rot_event) begin
      unique case (state_q)
        ST_LOAD_A: begin
          load_a = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_LOAD_B;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        ST_LOAD_B: begin
          load_b = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_OP;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        ST_OP: begin
          op_d    = Y[0];
          res_upd = 1'b1;
          valid_d = 1'b1;
          state_d = ST_RESULT;
        end
        ST_RESULT: begin
          valid_d = 1'b0;
          clr_ops = 1'b1;
          k_d     = '0;
          state_d = ST_LOAD_A;
        end
        default: state_d = ST_LOAD_A;
      endcase
    end
  end

  // Entry index k selects nibble NIB-1-k; the top nibble is clipped to WIDTH.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    localparam int            LO    = gi * 4;
    localparam int            HI    = (gi * 4 + 3 > WIDTH - 1) ? WIDTH - 1 : gi * 4 + 3;
    localparam logic [KW-1:0] K_SEL = KW'(NIB - 1 - gi);

    logic wr_a, wr_b;

    assign wr_a        = load_a && (k_q == K_SEL);
    assign wr_b        = load_b && (k_q == K_SEL);
    assign a_d[HI:LO]  = clr_ops ? '0 : (wr_a ? Y[HI-LO:0] : a_q[HI:LO]);
    assign b_d[HI:LO]  = clr_ops ? '0 : (wr_b ? Y[HI-LO:0] : b_q[HI:LO]);
  end

  // Subtraction is A + ~B + 1, so carry=1 means no borrow.
  assign b_eff    = op_d ? ~b_q : b_q;
  assign res_full = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_d};

  assign sum_d   = res_upd ? res_full[WIDTH-1:0] : sum_q;
  assign carry_d = res_upd ? res_full[WIDTH]     : carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rot_meta_q <= 2'b00;
      rot_sync_q <= 2'b00;
      rq_q       <= 1'b0;
      rq_prev_q  <= 1'b0;
      state_q    <= ST_LOAD_A;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      rot_meta_q <= {ROT_B, ROT_A};
      rot_sync_q <= rot_meta_q;
      rq_q       <= rq_d;
      rq_prev_q  <= rq_q;
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      valid_q    <= valid_d;
    end
  end

`ifdef ROT_ADDSUB_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Overflow: both addends share a sign and the result sign differs from it.
  assign ovf_d = res_upd ? ((a_q[WIDTH-1] == b_eff[WIDTH-1]) && (res_full[WIDTH-1] != a_q[WIDTH-1]))
                         : ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign sum   = sum_q;
  assign carry = carry_q;
  assign valid = valid_q;
  assign state = state_q;

endmodule
